// File: rtl/pdcch_collect_pkg.sv
// Shared types and constants for the PDCCH byte collector: FSM encodings,
// FIFO entry layout and the lane-keep helper.
package pdcch_collect_pkg;

  localparam int unsigned DATA_IN_WIDTH  = 8;
  localparam int unsigned DATA_OUT_WIDTH = 64;
  localparam int unsigned BYTES_PER_WORD = DATA_OUT_WIDTH / 8;
  localparam int unsigned IDX_WIDTH      = $clog2(BYTES_PER_WORD);
  localparam int unsigned FIFO_DEPTH     = 16;
  localparam int unsigned LEN_WIDTH      = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_DONE    = 2'd2;

  typedef struct packed {
    logic                      last;
    logic [BYTES_PER_WORD-1:0] keep;
    logic [DATA_OUT_WIDTH-1:0] data;
  } collect_entry_t;

  // Contiguous keep mask covering lanes 0..idx.
  function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [IDX_WIDTH-1:0] idx);
    logic [BYTES_PER_WORD-1:0] m;
    m = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      m[k] = (IDX_WIDTH'(k) <= idx);
    end
    return m;
  endfunction

endpackage

// File: rtl/pdcch_collect_fifo.sv
// First-word-fall-through FIFO of packed collector entries; head reads as zero
// while empty so downstream outputs idle at 0.
module pdcch_collect_fifo
  import pdcch_collect_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  collect_entry_t push_entry,
  input  logic           pop,
  output collect_entry_t head,
  output logic           full,
  output logic           empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  collect_entry_t mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  // Pointers carry an extra wrap bit to separate full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pdcch_byte_collector.sv
// Packs an 8-bit byte stream LSB-first into 64-bit words per configured frame
// length and re-emits them through a FWFT FIFO with keep/last.
module pdcch_byte_collector
  import pdcch_collect_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LEN_WIDTH-1:0]      cfg_frame_len,
  input  logic                      cfg_valid,
  input  logic [DATA_IN_WIDTH-1:0]  s_axis_collect_data,
  input  logic                      s_axis_collect_valid,
  output logic                      s_axis_collect_ready,
  output logic [DATA_OUT_WIDTH-1:0] m_axis_collect_data,
  output logic [BYTES_PER_WORD-1:0] m_axis_collect_keep,
  output logic                      m_axis_collect_last,
  output logic                      m_axis_collect_valid,
  input  logic                      m_axis_collect_ready,
  output logic                      busy,
  output logic                      frame_done
);

  state_t                    state;
  state_t                    next_state;
  logic [IDX_WIDTH-1:0]      byte_idx;
  logic [LEN_WIDTH-1:0]      remaining;
  logic [DATA_OUT_WIDTH-1:0] shift_reg;

  logic           accept_c;
  logic           last_byte_c;
  logic           push_c;
  collect_entry_t push_entry_c;
  collect_entry_t head_entry;
  logic           fifo_full;
  logic           fifo_empty;

  assign s_axis_collect_ready = (state == ST_COLLECT) && !fifo_full;
  assign accept_c    = s_axis_collect_valid && s_axis_collect_ready;
  assign last_byte_c = (remaining == LEN_WIDTH'(1));
  assign push_c      = accept_c &&
                       ((byte_idx == IDX_WIDTH'(BYTES_PER_WORD - 1)) || last_byte_c);

  // Lanes above byte_idx are already zero because shift_reg clears on every push.
  always_comb begin
    push_entry_c      = '0;
    push_entry_c.data = shift_reg |
                        (DATA_OUT_WIDTH'(s_axis_collect_data) << {byte_idx, 3'b000});
    push_entry_c.keep = keep_mask(byte_idx);
    push_entry_c.last = last_byte_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (cfg_valid && (cfg_frame_len != '0)) next_state = ST_COLLECT;
      ST_COLLECT: if (accept_c && last_byte_c)            next_state = ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
    end else begin
      if ((state == ST_IDLE) && cfg_valid && (cfg_frame_len != '0)) begin
        remaining <= cfg_frame_len;
      end else if (accept_c) begin
        remaining <= remaining - LEN_WIDTH'(1);
      end
      if (accept_c) begin
        if (push_c) begin
          shift_reg <= '0;
          byte_idx  <= '0;
        end else begin
          shift_reg <= push_entry_c.data;
          byte_idx  <= byte_idx + IDX_WIDTH'(1);
        end
      end
    end
  end

  pdcch_collect_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_c),
    .push_entry (push_entry_c),
    .pop        (m_axis_collect_ready),
    .head       (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign m_axis_collect_valid = !fifo_empty;
  assign m_axis_collect_data  = head_entry.data;
  assign m_axis_collect_keep  = head_entry.keep;
  assign m_axis_collect_last  = head_entry.last;
  assign busy                 = (state != ST_IDLE);
  assign frame_done           = (state == ST_DONE);

endmodule

// File: tb/tb_pdcch_byte_collector.sv
// Scoreboard bench for pdcch_byte_collector: stimulus queues expected words,
// a negedge monitor pops and compares each word the DUT hands off.
module tb_pdcch_byte_collector;
  import pdcch_collect_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cfg_frame_len = '0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        busy;
  logic        frame_done;

  int unsigned    n_pass = 0;
  int unsigned    n_total = 0;
  int             done_cnt = 0;
  int             rdy_mode = 0;
  collect_entry_t exp_q[$];
  collect_entry_t mon_e;
  logic [7:0]     frame_bytes[$];

  pdcch_byte_collector dut (
    .clk                  (clk),
    .reset                (reset),
    .cfg_frame_len        (cfg_frame_len),
    .cfg_valid            (cfg_valid),
    .s_axis_collect_data  (s_data),
    .s_axis_collect_valid (s_valid),
    .s_axis_collect_ready (s_ready),
    .m_axis_collect_data  (m_data),
    .m_axis_collect_keep  (m_keep),
    .m_axis_collect_last  (m_last),
    .m_axis_collect_valid (m_valid),
    .m_axis_collect_ready (m_ready),
    .busy                 (busy),
    .frame_done           (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: a handshake seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_done) done_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_word actual=%0h required=none", m_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", m_data, mon_e.data);
          check("word_keep", 64'(m_keep), 64'(mon_e.keep));
          check("word_last", 64'(m_last), 64'(mon_e.last));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int len);
    cfg_frame_len = 16'(len);
    cfg_valid = 1'b1;
    sync();
    cfg_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit throttle);
    if (throttle) begin
      while ($urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        sync();
      end
    end
    s_data  = b;
    s_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (s_ready) begin
        sync();
        s_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 64'(s_ready), 64'(1));
    sync();
    s_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input bit throttle);
    for (int i = from; i < to; i++) send_byte(frame_bytes[i], throttle);
  endtask

  // Reference packer: LSB-first lanes, push on full word or frame end.
  task automatic model_frame();
    collect_entry_t e;
    int idx;
    e = '0;
    idx = 0;
    for (int i = 0; i < frame_bytes.size(); i++) begin
      e.data[8*idx +: 8] = frame_bytes[i];
      e.keep[idx] = 1'b1;
      if (idx == 7 || i == frame_bytes.size() - 1) begin
        e.last = (i == frame_bytes.size() - 1);
        exp_q.push_back(e);
        e = '0;
        idx = 0;
      end else begin
        idx++;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check({name, "_m_valid_idle"}, 64'(m_valid), 64'(0));
    sync();
  endtask

  task automatic check_all_zero(input string name);
    @(negedge clk);
    check({name, "_s_ready"}, 64'(s_ready), 64'(0));
    check({name, "_m_valid"}, 64'(m_valid), 64'(0));
    check({name, "_m_data"}, m_data, 64'(0));
    check({name, "_m_keep"}, 64'(m_keep), 64'(0));
    check({name, "_m_last"}, 64'(m_last), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_done"}, 64'(frame_done), 64'(0));
  endtask

  initial begin
    int d0;

    repeat (3) @(posedge clk);
    check_all_zero("reset");
    sync();
    reset = 1'b1;
    sync();

    // 1: two full words, m_ready held high
    frame_bytes.delete();
    for (int i = 0; i < 16; i++) frame_bytes.push_back(8'(i));
    exp_q.push_back('{last: 1'b0, keep: 8'hFF, data: 64'h0706050403020100});
    exp_q.push_back('{last: 1'b1, keep: 8'hFF, data: 64'h0F0E0D0C0B0A0908});
    d0 = done_cnt;
    cfg(16);
    @(negedge clk);
    check("t1_busy", 64'(busy), 64'(1));
    sync();
    send_range(0, 16, 1'b0);
    drain("t1");
    check("t1_done_pulses", 64'(done_cnt - d0), 64'(1));

    // 2: short frame, partial word
    frame_bytes.delete();
    frame_bytes.push_back(8'hA1);
    frame_bytes.push_back(8'hA2);
    frame_bytes.push_back(8'hA3);
    exp_q.push_back('{last: 1'b1, keep: 8'h07, data: 64'h0000000000A3A2A1});
    cfg(3);
    send_range(0, 3, 1'b0);
    drain("t2");

    // 3: backpressure fills the FIFO after 128 bytes
    rdy_mode = 1;
    sync();
    frame_bytes.delete();
    for (int i = 0; i < 136; i++) frame_bytes.push_back(8'((i * 7 + 3) & 255));
    model_frame();
    cfg(136);
    send_range(0, 128, 1'b0);
    @(negedge clk);
    check("t3_s_ready_full", 64'(s_ready), 64'(0));
    check("t3_busy", 64'(busy), 64'(1));
    check("t3_m_valid", 64'(m_valid), 64'(1));
    sync();
    rdy_mode = 0;
    send_range(128, 136, 1'b0);
    drain("t3");

    // 4: zero length is ignored
    cfg(0);
    repeat (2) sync();
    check_all_zero("t4");
    sync();

    // 5: reset mid-frame, then a clean 8-byte frame
    frame_bytes.delete();
    for (int i = 0; i < 16; i++) frame_bytes.push_back(8'(8'hC0 + i));
    cfg(16);
    send_range(0, 5, 1'b0);
    reset = 1'b0;
    check_all_zero("t5_reset");
    sync();
    reset = 1'b1;
    sync();
    check_all_zero("t5_after");
    sync();
    frame_bytes.delete();
    for (int i = 0; i < 8; i++) frame_bytes.push_back(8'(8'h10 + i));
    exp_q.push_back('{last: 1'b1, keep: 8'hFF, data: 64'h1716151413121110});
    cfg(8);
    send_range(0, 8, 1'b0);
    drain("t5");

    // 6: random throttling both sides, stray cfg_valid mid-frame
    rdy_mode = 2;
    frame_bytes.delete();
    for (int i = 0; i < 37; i++) frame_bytes.push_back(8'(i) ^ 8'h5A);
    model_frame();
    d0 = done_cnt;
    cfg(37);
    send_range(0, 10, 1'b1);
    cfg(3);
    @(negedge clk);
    check("t6_busy_after_cfg", 64'(busy), 64'(1));
    sync();
    send_range(10, 37, 1'b1);
    drain("t6");
    check("t6_done_pulses", 64'(done_cnt - d0), 64'(1));
    rdy_mode = 0;
    repeat (3) sync();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
